// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [15:0] DEFAULT_TX_ADDR   = 16'hf001;
    localparam logic [15:0] DEFAULT_STAT_ADDR = 16'hf002;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; pop_data shows the head entry whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; empty pointers make stale contents invisible.
    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO, written through a byte-wide MMIO data register
// with a status register reporting {ovf, full, busy}.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int          CLK_DIV    = 234,
    parameter int          DATA_BITS  = 8,
    parameter int          PARITY     = 0,
    parameter int          STOP_BITS  = 1,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] TX_ADDR    = DEFAULT_TX_ADDR,
    parameter logic [15:0] STAT_ADDR  = DEFAULT_STAT_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] mmio_addr,
    input  logic [7:0]  mmio_wdata,
    input  logic        mmio_we,
    output logic [7:0]  mmio_rdata,
    output logic        tx,
    output logic        busy
);

    localparam int                BEAT_W    = $clog2(CLK_DIV);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CLK_DIV - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t             state, state_next;
    logic [BEAT_W-1:0]     beat_cnt, beat_next;
    logic [2:0]            bit_cnt, bit_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic                  parity_bit, parity_next;
    logic                  tx_next;
    logic                  ovf;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]  fifo_dout;
    logic                  tx_write, ovf_set, ovf_clr;
    logic                  beat_end, start_frame;

    assign tx_write  = mmio_we && (mmio_addr == TX_ADDR);
    assign fifo_push = tx_write && !fifo_full;
    assign ovf_set   = tx_write && fifo_full;
    assign ovf_clr   = mmio_we && (mmio_addr == STAT_ADDR) && mmio_wdata[2];
    assign busy      = (state != TX_IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mmio_wdata[DATA_BITS-1:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        mmio_rdata = 8'h00;
        if (mmio_addr == STAT_ADDR)
            mmio_rdata = {5'b0, ovf, fifo_full, busy};
    end

    // Next-state logic; tx is computed one cycle ahead so the line itself is a flop.
    always_comb begin
        state_next  = state;
        beat_next   = beat_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        tx_next     = tx;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        beat_end    = (beat_cnt == BEAT_LAST);

        if (state != TX_IDLE)
            beat_next = beat_end ? '0 : beat_cnt + 1'b1;

        case (state)
            TX_IDLE: begin
                if (!fifo_empty)
                    start_frame = 1'b1;
            end
            TX_START: begin
                if (beat_end) begin
                    state_next = TX_DATA;
                    tx_next    = shift_reg[0];
                    bit_next   = '0;
                end
            end
            TX_DATA: begin
                if (beat_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_next = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_next = TX_PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = TX_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                        bit_next   = bit_cnt + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (beat_end) begin
                    state_next = TX_STOP;
                    tx_next    = 1'b1;
                    bit_next   = '0;
                end
            end
            TX_STOP: begin
                if (beat_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_next = TX_IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Popping and driving the start bit on the same edge keeps frames gap-free.
        if (start_frame) begin
            fifo_pop    = 1'b1;
            shift_next  = fifo_dout;
            parity_next = (PARITY == PARITY_ODD) ? ~(^fifo_dout) : ^fifo_dout;
            tx_next     = 1'b0;
            state_next  = TX_START;
            beat_next   = '0;
            bit_next    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= TX_IDLE;
            beat_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state      <= state_next;
            beat_cnt   <= beat_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
        end
    end

    // A dropped write wins over a simultaneous clear so no overflow goes unreported.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: one 8N1 instance and one 7E2 instance, both CLK_DIV=4 with a 4-deep FIFO;
// a monitor per line captures whole frames cycle by cycle and checks them against queued expectations.
module tb_uart_tx_fifo;

    localparam logic [15:0] TX_ADDR   = 16'hf001;
    localparam logic [15:0] STAT_ADDR = 16'hf002;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_wdata;
    logic        we_a, we_b;
    logic [7:0]  rdata_a, rdata_b;
    logic        tx_a, tx_b, busy_a, busy_b;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int last_write = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         contiguous;
        int         start;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_fifo #(
        .CLK_DIV (4), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4),
        .TX_ADDR (TX_ADDR), .STAT_ADDR (STAT_ADDR)
    ) dut_a (
        .clock (clock), .reset (reset), .mmio_addr (mmio_addr), .mmio_wdata (mmio_wdata),
        .mmio_we (we_a), .mmio_rdata (rdata_a), .tx (tx_a), .busy (busy_a)
    );

    uart_tx_fifo #(
        .CLK_DIV (4), .DATA_BITS (7), .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (4),
        .TX_ADDR (TX_ADDR), .STAT_ADDR (STAT_ADDR)
    ) dut_b (
        .clock (clock), .reset (reset), .mmio_addr (mmio_addr), .mmio_wdata (mmio_wdata),
        .mmio_we (we_b), .mmio_rdata (rdata_b), .tx (tx_b), .busy (busy_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic txLine(input int id);
        return (id == 0) ? tx_a : tx_b;
    endfunction

    function automatic int frameLen(input int id);
        return (id == 0) ? 40 : 44;
    endfunction

    // Reference line waveform, one entry per clock, index 0 = first start-bit cycle.
    function automatic logic [63:0] expectedWave(input int id, input logic [7:0] data);
        logic [15:0] lvl  = '0;
        logic [63:0] w    = '0;
        int          n    = 1;
        int          nb   = (id == 0) ? 8 : 7;
        int          ones = 0;
        for (int i = 0; i < nb; i++) begin
            lvl[n] = data[i];
            if (data[i]) ones++;
            n++;
        end
        if (id == 1) begin
            lvl[n]   = (ones % 2) != 0;
            lvl[n+1] = 1'b1;
            lvl[n+2] = 1'b1;
            n += 3;
        end else begin
            lvl[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++)
            for (int c = 0; c < 4; c++)
                w[b*4 + c] = lvl[b];
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [15:0] addr, input logic [7:0] data,
                                 input bit expect_frame, input bit contiguous);
        exp_t e;
        @(negedge clock);
        mmio_addr  = addr;
        mmio_wdata = data;
        if (id == 0) we_a = 1'b1;
        else         we_b = 1'b1;
        @(posedge clock);
        #1;
        we_a = 1'b0;
        we_b = 1'b0;
        last_write = cyc;
        if (expect_frame) begin
            e.id         = id;
            e.data       = data;
            e.contiguous = contiguous;
            e.start      = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic readStatus(input int id, input logic [15:0] addr, input logic [7:0] expected, input string name);
        mmio_addr = addr;
        #1;
        checkOutput(name, (id == 0) ? rdata_a : rdata_b, expected);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic waitIdle(input int id, input int limit, input string name);
        int n = 0;
        @(negedge clock);
        while (((id == 0) ? busy_a : busy_b) && n < limit) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, (id == 0) ? busy_a : busy_b, 1'b0);
    endtask

    task automatic monitor(input int id);
        logic [63:0] wave;
        int          start;
        int          len;
        int          next_start = -1;
        bit          aborted;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (reset || txLine(id) !== 1'b0) continue;
            start   = cyc;
            len     = frameLen(id);
            wave    = '0;
            aborted = 1'b0;
            for (int i = 1; i < len; i++) begin
                @(negedge clock);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
                wave[i] = txLine(id);
            end
            if (aborted) continue;
            if (exp_q.size() == 0 || exp_q[0].id != id) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame line=%0d wave=%0h start=%0d", id, wave, start);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("frame_%0d_%02h", id, e.data), wave, expectedWave(id, e.data));
                checkOutput($sformatf("start_%0d_%02h", id, e.data), start,
                            e.contiguous ? next_start : e.start);
            end
            next_start = start + len;
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        reset      = 1'b1;
        mmio_addr  = 16'h0000;
        mmio_wdata = 8'h00;
        we_a       = 1'b0;
        we_b       = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_tx_a", tx_a, 1'b1);
        checkOutput("reset_busy_a", busy_a, 1'b0);
        checkOutput("reset_tx_b", tx_b, 1'b1);
        readStatus(0, STAT_ADDR, 8'h00, "reset_status_a");
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("idle_tx_a", tx_a, 1'b1);

        // Single 8N1 frame of 0x41 with busy timing.
        applyStimulus(0, TX_ADDR, 8'h41, 1'b1, 1'b0);
        w = last_write;
        waitUntil(w + 10);
        readStatus(0, STAT_ADDR, 8'h01, "status_busy");
        waitUntil(w + 40);
        checkOutput("busy_last_cycle", busy_a, 1'b1);
        @(negedge clock);
        checkOutput("busy_dropped", busy_a, 1'b0);

        // Three back-to-back writes must come out as contiguous frames in order.
        applyStimulus(0, TX_ADDR, 8'h01, 1'b1, 1'b0);
        applyStimulus(0, TX_ADDR, 8'h02, 1'b1, 1'b1);
        applyStimulus(0, TX_ADDR, 8'h03, 1'b1, 1'b1);
        waitIdle(0, 300, "burst_idle");

        // Overfill the 4-deep FIFO while a frame is on the line.
        applyStimulus(0, TX_ADDR, 8'h10, 1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(0, TX_ADDR, 8'h11, 1'b1, 1'b1);
        applyStimulus(0, TX_ADDR, 8'h12, 1'b1, 1'b1);
        applyStimulus(0, TX_ADDR, 8'h13, 1'b1, 1'b1);
        applyStimulus(0, TX_ADDR, 8'h14, 1'b1, 1'b1);
        applyStimulus(0, TX_ADDR, 8'h15, 1'b0, 1'b0);
        applyStimulus(0, TX_ADDR, 8'h16, 1'b0, 1'b0);
        @(negedge clock);
        readStatus(0, STAT_ADDR, 8'h07, "status_full_ovf");
        readStatus(0, TX_ADDR, 8'h00, "rdata_other_addr");
        applyStimulus(0, STAT_ADDR, 8'h04, 1'b0, 1'b0);
        @(negedge clock);
        readStatus(0, STAT_ADDR, 8'h03, "status_ovf_cleared");
        waitIdle(0, 400, "overflow_idle");
        readStatus(0, STAT_ADDR, 8'h00, "status_drained");

        // 7E2 frames: 0x35 gives parity 0, 0x07 gives parity 1.
        applyStimulus(1, TX_ADDR, 8'h35, 1'b1, 1'b0);
        w = last_write;
        waitUntil(w + 44);
        checkOutput("busy_b_last_cycle", busy_b, 1'b1);
        @(negedge clock);
        checkOutput("busy_b_dropped", busy_b, 1'b0);
        applyStimulus(1, TX_ADDR, 8'h07, 1'b1, 1'b0);
        waitIdle(1, 200, "b_idle");

        // Reset in the middle of data bit 3 with a second byte still queued.
        applyStimulus(0, TX_ADDR, 8'h55, 1'b1, 1'b0);
        w = last_write;
        applyStimulus(0, TX_ADDR, 8'h66, 1'b1, 1'b1);
        waitUntil(w + 18);
        reset = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("abort_tx", tx_a, 1'b1);
        checkOutput("abort_busy", busy_a, 1'b0);
        readStatus(0, STAT_ADDR, 8'h00, "abort_status");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        checkOutput("post_reset_tx", tx_a, 1'b1);
        checkOutput("post_reset_busy", busy_a, 1'b0);

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 500) begin
                @(negedge clock);
                n++;
            end
        end
        checkOutput("pending_frames", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
